// File: rtl/thresh_pkg.sv
// Shared constants, status/state types and address helper for the threshold batch loader.
package thresh_pkg;

    localparam logic [12:0] THRESH_CONTROL = 13'h1800;
    localparam logic [12:0] SUBTHRESH_BASE = 13'h0800;
    localparam int unsigned UPDATE_REQ_BIT = 1;

    typedef enum logic [1:0] {
        StsOk      = 2'd0,
        StsBusErr  = 2'd1,
        StsLenErr  = 2'd2,
        StsTimeout = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        StIdle,
        StGet,
        StWr,
        StReq,
        StGap,
        StPoll,
        StDone
    } state_e;

    // Even words are trigger thresholds at 4n, odd words subthresholds at 0x800 + 4n.
    // Beam index stays below 512, so bit 11 of 4n is always clear and OR acts as add.
    function automatic logic [12:0] word_addr(input logic [11:0] k);
        logic [12:0] a;
        a = {k[11:1], 2'b00};
        if (k[0]) begin
            a = a | SUBTHRESH_BASE;
        end
        return a;
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-transfer WISHBONE master: latches one request, holds cyc/stb until ack or err.
module wb_single_master (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [12:0] i_adr,
    input  logic [31:0] i_dat,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [12:0] o_adr,
    output logic [31:0] o_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    logic        r_cyc;
    logic        r_we;
    logic [12:0] r_adr;
    logic [31:0] r_dat;

    // Launch a transfer when idle; adr/dat/we stay frozen until ack or err closes it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (r_cyc) begin
            if (i_wb_ack || i_wb_err) begin
                r_cyc <= 1'b0;
            end
        end else if (i_req) begin
            r_cyc <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_dat;
        end
    end

    // Error takes priority over a simultaneous ack
    assign o_err   = r_cyc && i_wb_err;
    assign o_ack   = r_cyc && i_wb_ack && !i_wb_err;
    assign o_rdata = i_wb_dat;
    assign o_cyc   = r_cyc;
    assign o_stb   = r_cyc;
    assign o_we    = r_we;
    assign o_adr   = r_adr;
    assign o_dat   = r_dat;

endmodule

// File: rtl/thresh_batch_loader.sv
// Loads one full threshold set over WISHBONE, then requests the commit and polls until done.
module thresh_batch_loader
    import thresh_pkg::*;
#(
    parameter int unsigned NBEAMS   = 46,
    parameter int unsigned POLL_GAP = 16,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [17:0] s_thr_tdata,
    input  logic        s_thr_tvalid,
    output logic        s_thr_tready,
    input  logic        s_thr_tlast,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [12:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o
);

    localparam int unsigned NWORDS = 2 * NBEAMS;
    localparam int unsigned KW     = $clog2(NWORDS);
    localparam int unsigned GW     = $clog2(POLL_GAP + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] LAST_K = KW'(NWORDS - 1);

    state_e          r_state;
    status_e         r_status;
    logic [KW-1:0]   r_k;
    logic [17:0]     r_data;
    logic            r_len_err;
    logic            r_tready;
    logic            r_busy;
    logic            r_done;
    logic [GW-1:0]   r_gap;
    logic [TW-1:0]   r_tmo;

    logic            w_req;
    logic            w_we;
    logic [12:0]     w_adr;
    logic [31:0]     w_wdat;
    logic            w_ack;
    logic            w_err;
    logic [31:0]     w_rdata;
    logic            w_tmo_hit;
    logic            unused_rdata;

    assign w_tmo_hit    = (r_tmo >= TW'(TIMEOUT));
    assign unused_rdata = ^{w_rdata[31:2], w_rdata[0]};

    // Select the one bus request the current state needs
    always_comb begin
        w_req  = 1'b0;
        w_we   = 1'b0;
        w_adr  = '0;
        w_wdat = '0;
        unique case (r_state)
            StWr: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_adr  = word_addr(12'(r_k));
                w_wdat = {14'b0, r_data};
            end
            StReq: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_adr  = THRESH_CONTROL;
                w_wdat = 32'(1) << UPDATE_REQ_BIT;
            end
            StPoll: begin
                w_req  = 1'b1;
                w_adr  = THRESH_CONTROL;
            end
            default: begin
            end
        endcase
    end

    wb_single_master u_wb (
        .i_clk    (wb_clk_i),
        .i_rst_n  (wb_rst_n_i),
        .i_req    (w_req),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_dat    (w_wdat),
        .o_ack    (w_ack),
        .o_err    (w_err),
        .o_rdata  (w_rdata),
        .o_cyc    (wbm_cyc_o),
        .o_stb    (wbm_stb_o),
        .o_we     (wbm_we_o),
        .o_adr    (wbm_adr_o),
        .o_dat    (wbm_dat_o),
        .i_wb_dat (wbm_dat_i),
        .i_wb_ack (wbm_ack_i),
        .i_wb_err (wbm_err_i)
    );

    // Load sequencer: fetch word, write it, then request update and poll for completion
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= StIdle;
            r_status  <= StsOk;
            r_k       <= '0;
            r_data    <= '0;
            r_len_err <= 1'b0;
            r_tready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_gap     <= '0;
            r_tmo     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_state   <= StGet;
                        r_status  <= StsOk;
                        r_busy    <= 1'b1;
                        r_tready  <= 1'b1;
                        r_k       <= '0;
                        r_len_err <= 1'b0;
                        r_tmo     <= '0;
                    end
                end
                StGet: begin
                    if (s_thr_tvalid) begin
                        r_tready  <= 1'b0;
                        r_data    <= s_thr_tdata;
                        // A misplaced tlast (early or missing) still gets its word written
                        r_len_err <= (s_thr_tlast != (r_k == LAST_K));
                        r_state   <= StWr;
                    end
                end
                StWr: begin
                    if (w_err) begin
                        r_state  <= StDone;
                        r_done   <= 1'b1;
                        r_status <= StsBusErr;
                    end else if (w_ack) begin
                        if (r_len_err) begin
                            r_state  <= StDone;
                            r_done   <= 1'b1;
                            r_status <= StsLenErr;
                        end else if (r_k == LAST_K) begin
                            r_state <= StReq;
                        end else begin
                            r_k      <= r_k + KW'(1);
                            r_tready <= 1'b1;
                            r_state  <= StGet;
                        end
                    end
                end
                StReq: begin
                    if (w_err) begin
                        r_state  <= StDone;
                        r_done   <= 1'b1;
                        r_status <= StsBusErr;
                    end else if (w_ack) begin
                        r_tmo   <= '0;
                        r_state <= StPoll;
                    end
                end
                StPoll: begin
                    if (!w_tmo_hit) begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                    // An open poll always completes before a timeout is honoured
                    if (w_err) begin
                        r_state  <= StDone;
                        r_done   <= 1'b1;
                        r_status <= StsBusErr;
                    end else if (w_ack) begin
                        if (!w_rdata[UPDATE_REQ_BIT]) begin
                            r_state  <= StDone;
                            r_done   <= 1'b1;
                            r_status <= StsOk;
                        end else if (w_tmo_hit) begin
                            r_state  <= StDone;
                            r_done   <= 1'b1;
                            r_status <= StsTimeout;
                        end else begin
                            r_gap   <= '0;
                            r_state <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (!w_tmo_hit) begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                    if (w_tmo_hit) begin
                        r_state  <= StDone;
                        r_done   <= 1'b1;
                        r_status <= StsTimeout;
                    end else if (r_gap == GW'(POLL_GAP - 1)) begin
                        r_state <= StPoll;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_thr_tready = r_tready;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign status_o     = r_status;
    assign wbm_sel_o    = 4'hF;

endmodule

// File: doc/thresh_batch_loader.md
Name: thresh_batch_loader

Overview:
- WISHBONE master that loads one complete threshold set into the threshold target and commits it.
- Takes 18-bit threshold words from an AXI4-Stream-style input and writes each to the threshold target's primary or subthreshold slot.
- Then writes the update-request bit in THRESH_CONTROL (0x1800) and polls that register until the update completes in the aclk domain.
- Sits between the threshold servo/host command logic and the threshold WISHBONE target, on the same bus clock.

Parameters:
- NBEAMS, 46: beams per load; a load is 2*NBEAMS stream words.
- POLL_GAP, 16: idle wb_clk_i cycles between consecutive status polls.
- TIMEOUT, 4096: maximum poll cycles (counted from the first poll issue) before declaring a timeout.

Ports:
- wb_clk_i  in  1  bus clock; the only clock.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse that begins a load; ignored while busy_o=1.
- s_thr_tdata  in  18  threshold word, unsigned.
- s_thr_tvalid  in  1  word valid.
- s_thr_tready  out  1  word accepted this cycle.
- s_thr_tlast  in  1  asserted on word 2*NBEAMS-1.
- wbm_cyc_o  out  1  WB cycle.
- wbm_stb_o  out  1  WB strobe.
- wbm_we_o  out  1  WB write enable.
- wbm_adr_o  out  13  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte select; always 4'hF.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  WB ack.
- wbm_err_i  in  1  WB error.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse at the end of every load, success or failure.
- status_o  out  2  result of the last load, held until the next start_i: 0 OK, 1 BUS_ERR, 2 LEN_ERR, 3 TIMEOUT.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0; state IDLE; word counter 0.
- Reset mid-operation drops wbm_cyc_o immediately; no update request is issued.
- Word order on the stream: beam0 trig, beam0 sub, beam1 trig, ... Word k addresses beam n=k>>1.
  - Trig word: wbm_adr_o = 4n.
  - Sub word: wbm_adr_o = 0x800 + 4n.
  - wbm_dat_o = {14'b0, tdata}.
- FSM states: IDLE, GET, WR, REQ, GAP, POLL, DONE.
- IDLE: on start_i, clear status_o, go to GET. busy_o=1 in every state except IDLE.
- GET: s_thr_tready=1 only in GET. On tvalid, capture tdata and tlast.
  - If tlast is set and k<2*NBEAMS-1, or tlast is clear and k=2*NBEAMS-1: still perform the write, then DONE with LEN_ERR (no update request).
  - Otherwise go to WR.
- WR: cyc/stb/we=1 until ack.
  - On ack: if k=2*NBEAMS-1 go to REQ, else k<=k+1 and go to GET.
  - Only one word is ever in flight, so at most one word is buffered.
- REQ: write 0x1800 with data 0x0000_0002 (update_requested=1, reset_update=0). On ack go to POLL.
- GAP: count POLL_GAP cycles, then go to POLL.
- POLL: read 0x1800 (we=0). On ack: if wbm_dat_i[1]=0, DONE with OK; otherwise go to GAP.
- Timeout counter: starts on entry to the first POLL and counts every cycle in POLL/GAP. When it reaches TIMEOUT, go to DONE with TIMEOUT once any open cycle has acked; cyc is never dropped mid-transfer.
- wbm_err_i in any bus state ends the cycle and goes to DONE with BUS_ERR.
- wbm_ack_i and wbm_err_i in the same cycle: err wins.
- DONE: assert done_o for 1 cycle, update status_o, return to IDLE.
- start_i in DONE is ignored.
- stb never deasserts before ack/err; address and data are stable while stb=1.
- Back-to-back loads: start_i in the cycle after done_o is accepted.

Decomposition:
- thresh_pkg holds:
  - THRESH_CONTROL = 13'h1800
  - SUBTHRESH_BASE = 13'h800
  - UPDATE_REQ_BIT = 1
  - status enum (OK, BUS_ERR, LEN_ERR, TIMEOUT)
  - FSM state typedef
- One sub-module: wb_single_master.
  - Accepts a single request (adr, dat, we) with a req/ack handshake.
  - Drives cyc/stb, returns rdata/err.
  - Reused for both the data writes and the control writes/polls.

Test Plan:
- NBEAMS=4, words 0x00100..0x00107, tlast on word 7, target acks after 2 cycles:
  - Writes go to 0x000,0x800,0x004,0x804,0x008,0x808,0x00C,0x80C with the matching data.
  - Then a write of 0x2 to 0x1800; poll returns 0x2 twice, then 0x0.
  - Required: done_o pulses once, status_o=0.
- tlast on word 5 (NBEAMS=4): 6 writes issued, no access to 0x1800, status_o=2.
- wbm_err_i on the third write: cyc drops, no further accesses, status_o=1, busy_o=0 the cycle after done_o.
- Poll always returns 0x2, TIMEOUT=64: done_o within 64 cycles of the first poll plus one bus transfer, status_o=3.
- wb_rst_n_i pulsed low during word 3's WR: cyc, stb and busy_o go to 0 asynchronously; a new start_i afterwards reloads from word 0.
- tvalid gaps of 5 cycles between words and start_i during busy: outputs identical to the first scenario; the extra start_i is ignored.
